// File: rtl/morningjava_square.sv
// morningjava_square: iterative unsigned squarer, data_out = data_in * data_in.
// One multiplier bit is processed per clock (serial shift-add) under a
// start/busy/done handshake. The result is held until the next completion.
// Optional build macro: SQUARE_EARLY_EXIT_EN. When defined, CALC stops as soon
// as no set multiplier bits remain. Result values are the same in both builds.
module morningjava_square #(
  parameter int G_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [G_WIDTH/2-1:0] data_in,
  output logic                 busy,
  output logic                 done,
  output logic [G_WIDTH-1:0]   data_out
);

  localparam int N  = G_WIDTH / 2;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state;
  logic [G_WIDTH-1:0] mcand;    // zero-extended operand, shifted by cnt when added
  logic [N-1:0]       mplier;   // remaining multiplier bits, LSB is the current bit
  logic [G_WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;
  logic [G_WIDTH-1:0] acc_next;
  logic               last;

  // Next accumulator value and end-of-calculation detection for the current CALC cycle
  always_comb begin
    acc_next = acc;
    if (mplier[0]) acc_next = acc + (mcand << cnt);
`ifdef SQUARE_EARLY_EXIT_EN
    // Stop once the bit being processed is the last set bit (or there are none)
    last = ((mplier >> 1) == '0) || (cnt == CW'(N - 1));
`else
    last = (cnt == CW'(N - 1));
`endif
  end

  // Handshake FSM with registered busy/done and the shift-add datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      data_out <= '0;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      cnt      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          busy <= 1'b0;
          if (start) begin
            mcand  <= G_WIDTH'(data_in);
            mplier <= data_in;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= CALC;
          end else begin
            state  <= IDLE;
          end
        end
        CALC: begin
          acc    <= acc_next;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (last) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            data_out <= acc_next;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_morningjava_square.sv
// Self-checking bench for morningjava_square (G_WIDTH=8, N=4).
// Reference: square = a*a; latency counted in clock edges from the edge at
// which start is applied, up to the edge after which done is seen.
// Fixed build: N+1. Early-exit build: 1 + max(1, bit length of a).
module tb_morningjava_square;

  localparam int G_WIDTH = 8;
  localparam int N       = G_WIDTH / 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [N-1:0]       data_in;
  logic               busy;
  logic               done;
  logic [G_WIDTH-1:0] data_out;

  int n_checks = 0;
  int n_errors = 0;

  morningjava_square #(.G_WIDTH(G_WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .data_in  (data_in),
    .busy     (busy),
    .done     (done),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_lat(input int a);
`ifdef SQUARE_EARLY_EXIT_EN
    int bl = 0;
    for (int i = 0; i < N; i++) if ((a >> i) & 1) bl = i + 1;
    return 1 + ((bl < 1) ? 1 : bl);
`else
    return N + 1;
`endif
  endfunction

  // Wait (bounded) for done; busy must be high on every cycle before it
  task automatic wait_done(input bit drop, input bit toggle, output int lat);
    lat = 0;
    for (int i = 1; i <= N + 3; i++) begin
      @(posedge clk); #1;
      if (i == 1 && drop) start = 1'b0;
      chk("busy_done_excl", int'(busy & done), 0);
      if (done) begin lat = i; break; end
      chk("busy", int'(busy), 1);
      if (toggle) data_in = N'($urandom);
    end
    if (lat == 0) chk("done_timeout", 0, 1);
  endtask

  task automatic check_hold(input int exp);
    @(posedge clk); #1;
    chk("done_pulse", int'(done), 0);
    chk("hold", int'(data_out), exp);
  endtask

  // Single operation with a one-cycle start pulse and noisy data_in during CALC
  task automatic run_op(input int a);
    int lat;
    @(posedge clk); #1;
    start   = 1'b1;
    data_in = N'(a);
    wait_done(1'b1, 1'b1, lat);
    chk("latency", lat, ref_lat(a));
    chk("square", int'(data_out), a * a);
    check_hold(a * a);
  endtask

  // start held high: first operand captured, second accepted at DONE
  task automatic run_b2b(input int a, input int b);
    int lat;
    @(posedge clk); #1;
    start   = 1'b1;
    data_in = N'(a);
    wait_done(1'b0, 1'b1, lat);
    chk("b2b_lat1", lat, ref_lat(a));
    chk("b2b_sq1", int'(data_out), a * a);
    data_in = N'(b);
    wait_done(1'b1, 1'b1, lat);
    chk("b2b_lat2", lat, ref_lat(b));
    chk("b2b_sq2", int'(data_out), b * b);
    check_hold(b * b);
  endtask

  initial begin
    int a;
    rst = 1'b1; start = 1'b0; data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_dout", int'(data_out), 0);
    rst = 1'b0;

    run_op(11);
    run_op(15);
    run_op(0);
    run_op(1);
    run_op(3);
    run_op(8);

    run_b2b(2, 7);
    run_b2b(13, 6);

    for (int i = 0; i < 20; i++) begin
      a = int'($urandom_range(0, 15));
      run_op(a);
    end

    // Reset two edges into an operation aborts it
    @(posedge clk); #1;
    start = 1'b1; data_in = N'(13);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_dout", int'(data_out), 0);
    for (int i = 0; i < N + 3; i++) begin
      @(posedge clk); #1;
      chk("no_late_done", int'(done), 0);
    end

    run_op(9);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
